// File: rtl/sat_accum_pkg.sv
// Shared types and the saturating add used by sat_accum_arb.
// Operands are carried at OP_W bits, so IN_WIDTH and RES_WIDTH must both be at most 31.
package sat_accum_pkg;

  localparam int OP_W = 32;

  typedef logic signed [OP_W-1:0] op_t;

  typedef struct packed {
    logic sat;
    op_t  value;
  } sat_res_t;

  function automatic logic signed [OP_W:0] res_max(input int unsigned rw);
    return ((OP_W+1)'(1) <<< (rw - 1)) - (OP_W+1)'(1);
  endfunction

  function automatic logic signed [OP_W:0] res_min(input int unsigned rw);
    return -res_max(rw) - (OP_W+1)'(1);
  endfunction

  // The sum is one bit wider than the operands, so it cannot wrap before the clamp.
  function automatic sat_res_t sat_add(input op_t a, input op_t d, input int unsigned rw);
    logic signed [OP_W:0] sum;
    logic signed [OP_W:0] hi;
    logic signed [OP_W:0] lo;
    logic signed [OP_W:0] clamped;
    sat_res_t r;
    sum = (OP_W+1)'(a) + (OP_W+1)'(d);
    hi  = res_max(rw);
    lo  = res_min(rw);
    if (sum > hi) begin
      clamped = hi;
    end else if (sum < lo) begin
      clamped = lo;
    end else begin
      clamped = sum;
    end
    r.value = clamped[OP_W-1:0];
    r.sat   = (clamped != sum);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
// The pointer moves one past the winner and holds when nothing is granted.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (en && !found && req[cand[IW-1:0]]) begin
        found              = 1'b1;
        gnt[cand[IW-1:0]]  = 1'b1;
        gnt_idx            = cand[IW-1:0];
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sat_accum_arb.sv
// Time-shares one saturating add datapath between N_CH signed accumulators.
// One pipeline stage after the grant; result and updated accumulator appear two clocks after the handshake.
module sat_accum_arb
  import sat_accum_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int IN_WIDTH  = 16,
  parameter int RES_WIDTH = 16,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic [N_CH-1:0]           req_valid,
  input  logic [N_CH*IN_WIDTH-1:0]  req_delta,
  output logic [N_CH-1:0]           req_ready,
  input  logic [N_CH-1:0]           clr,
  output logic                      res_valid,
  output logic [CW-1:0]             res_ch,
  output logic [RES_WIDTH-1:0]      res_value,
  output logic                      res_sat,
  output logic [N_CH-1:0]           sat_flags,
  output logic [N_CH*RES_WIDTH-1:0] acc
);

  logic [CW-1:0] gnt_idx;
  logic          hs;

  logic signed [IN_WIDTH-1:0]  delta_arr [N_CH];
  logic signed [RES_WIDTH-1:0] acc_q     [N_CH];
  logic signed [RES_WIDTH-1:0] acc_d     [N_CH];
  logic [N_CH-1:0]             sat_flags_q, sat_flags_d;

  logic                        s1_valid_q, s1_valid_d;
  logic [CW-1:0]               s1_ch_q, s1_ch_d;
  logic signed [IN_WIDTH-1:0]  s1_delta_q, s1_delta_d;

  logic                        res_valid_q, res_valid_d;
  logic [CW-1:0]               res_ch_q, res_ch_d;
  logic [RES_WIDTH-1:0]        res_value_q, res_value_d;
  logic                        res_sat_q, res_sat_d;

  sat_res_t add_res;
  logic     unused_add_hi;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .req     (req_valid),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  assign hs = |req_ready;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign delta_arr[gi]                      = req_delta[gi*IN_WIDTH +: IN_WIDTH];
      assign acc[gi*RES_WIDTH +: RES_WIDTH]     = acc_q[gi];
    end
  endgenerate

  // The clamped value always fits RES_WIDTH, so the upper bits carry no information.
  always_comb add_res = sat_add(OP_W'(acc_q[s1_ch_q]), OP_W'(s1_delta_q), RES_WIDTH);
  assign unused_add_hi = ^add_res.value[OP_W-1:RES_WIDTH];

  always_comb begin
    s1_valid_d  = hs;
    s1_ch_d     = s1_ch_q;
    s1_delta_d  = s1_delta_q;
    acc_d       = acc_q;
    sat_flags_d = sat_flags_q;
    res_valid_d = s1_valid_q;
    res_ch_d    = res_ch_q;
    res_value_d = res_value_q;
    res_sat_d   = res_sat_q;
    if (hs) begin
      s1_ch_d    = gnt_idx;
      s1_delta_d = delta_arr[gnt_idx];
    end
    if (s1_valid_q) begin
      acc_d[s1_ch_q]       = add_res.value[RES_WIDTH-1:0];
      sat_flags_d[s1_ch_q] = sat_flags_q[s1_ch_q] | add_res.sat;
      res_ch_d             = s1_ch_q;
      res_value_d          = add_res.value[RES_WIDTH-1:0];
      res_sat_d            = add_res.sat;
    end
    // Clear wins over a same-cycle writeback; the result strobe still reports the sum.
    for (int i = 0; i < N_CH; i++) begin
      if (clr[i]) begin
        acc_d[i]       = '0;
        sat_flags_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_delta_q  <= '0;
      sat_flags_q <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_value_q <= '0;
      res_sat_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_delta_q  <= s1_delta_d;
      sat_flags_q <= sat_flags_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_value_q <= res_value_d;
      res_sat_q   <= res_sat_d;
      acc_q       <= acc_d;
    end
  end

  assign sat_flags = sat_flags_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_value = res_value_q;
  assign res_sat   = res_sat_q;

endmodule

// File: tb/tb_sat_accum_arb.sv
// Randomised scoreboard bench for sat_accum_arb against a cycle-level behavioural model.
module tb_sat_accum_arb;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int RW = 16;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic            clock = 1'b0;
  logic            reset;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N*IW-1:0] req_delta;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    clr;
  logic            res_valid;
  logic [1:0]      res_ch;
  logic [RW-1:0]   res_value;
  logic            res_sat;
  logic [N-1:0]    sat_flags;
  logic [N*RW-1:0] acc;

  always #5 clock = ~clock;

  sat_accum_arb #(.N_CH(N), .IN_WIDTH(IW), .RES_WIDTH(RW)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .req_valid (req_valid),
    .req_delta (req_delta),
    .req_ready (req_ready),
    .clr       (clr),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_value (res_value),
    .res_sat   (res_sat),
    .sat_flags (sat_flags),
    .acc       (acc)
  );

  typedef struct {
    int     ch;
    longint value;
    bit     sat;
    int     cyc;
  } exp_t;

  exp_t     sb[$];
  longint   m_acc[N];
  bit [N-1:0] m_flags = '0;
  int       m_ptr = 0;
  bit       m_s1_v = 1'b0;
  int       m_s1_ch = 0;
  longint   m_s1_d = 0;
  int       cyc = 0;
  int       n_checks = 0;
  int       n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*IW-1:0] pack4(input int d0, input int d1, input int d2, input int d3);
    return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endfunction

  function automatic int rand_delta();
    int sel;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: return int'($urandom_range(0, 400)) - 200;
      1: return int'($urandom_range(0, 65535)) - 32768;
      2: return 32767 - int'($urandom_range(0, 3));
      default: return -32768 + int'($urandom_range(0, 3));
    endcase
  endfunction

  // One clock cycle: drive inputs, check visible state, then advance the model.
  task automatic step(input logic r, input logic e, input logic [N-1:0] v,
                      input logic [N*IW-1:0] d, input logic [N-1:0] c);
    int g;
    logic [N-1:0] exp_ready;
    logic signed [IW-1:0] dslice;
    longint s;
    longint val;
    exp_t item;
    @(negedge clock);
    reset = r; en = e; req_valid = v; req_delta = d; clr = c;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("acc[%0d]", i), $signed(acc[i*RW +: RW]), m_acc[i]);
    end
    chk("sat_flags", sat_flags, m_flags);
    g = -1;
    if (e) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (!r) begin
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
    end
    if (r) begin
      for (int i = 0; i < N; i++) m_acc[i] = 0;
      m_flags = '0;
      m_ptr   = 0;
      m_s1_v  = 1'b0;
    end else begin
      if (m_s1_v) begin
        s   = m_acc[m_s1_ch] + m_s1_d;
        val = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
        item.ch    = m_s1_ch;
        item.value = val;
        item.sat   = (val != s);
        item.cyc   = cyc;
        sb.push_back(item);
        m_acc[m_s1_ch]   = val;
        m_flags[m_s1_ch] = m_flags[m_s1_ch] | item.sat;
      end
      for (int i = 0; i < N; i++) begin
        if (c[i]) begin
          m_acc[i]   = 0;
          m_flags[i] = 1'b0;
        end
      end
      m_s1_v = (g >= 0);
      if (g >= 0) begin
        dslice  = d[g*IW +: IW];
        m_s1_ch = g;
        m_s1_d  = dslice;
        m_ptr   = (g + 1) % N;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, '0, '0, '0);
  endtask

  exp_t mon_e;
  always @(negedge clock) begin
    if (res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL res_unexpected: got res_valid=1 ch=%0d value=%0d, expected no result", res_ch, $signed(res_value));
      end else begin
        mon_e = sb.pop_front();
        chk("res_latency", cyc, mon_e.cyc + 1);
        chk("res_ch", res_ch, mon_e.ch);
        chk("res_value", $signed(res_value), mon_e.value);
        chk("res_sat", res_sat, mon_e.sat);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    reset = 1'b1; en = 1'b0; req_valid = '0; req_delta = '0; clr = '0;
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);

    // Channel 0 plain accumulation: 5, -2, 98
    step(1'b0, 1'b1, 4'b0001, pack4(5, 0, 0, 0), '0);
    step(1'b0, 1'b1, 4'b0001, pack4(-7, 0, 0, 0), '0);
    step(1'b0, 1'b1, 4'b0001, pack4(100, 0, 0, 0), '0);
    idle(2);

    // Positive clamp on channel 1
    step(1'b0, 1'b1, 4'b0010, pack4(0, 32760, 0, 0), '0);
    step(1'b0, 1'b1, 4'b0010, pack4(0, 100, 0, 0), '0);
    step(1'b0, 1'b1, 4'b0010, pack4(0, -7, 0, 0), '0);
    idle(2);

    // Negative clamp on channel 2
    step(1'b0, 1'b1, 4'b0100, pack4(0, 0, -32768, 0), '0);
    step(1'b0, 1'b1, 4'b0100, pack4(0, 0, -1, 0), '0);
    idle(1);
    step(1'b0, 1'b1, '0, '0, 4'b0100);
    step(1'b0, 1'b1, 4'b0100, pack4(0, 0, -1, 0), '0);
    step(1'b0, 1'b1, 4'b0100, pack4(0, 0, -32768, 0), '0);
    idle(2);

    // Fairness from a freshly reset pointer, then with channel 1 idle
    step(1'b1, 1'b1, '0, '0, '0);
    repeat (8) step(1'b0, 1'b1, 4'b1111, pack4(1, 1, 1, 1), '0);
    repeat (4) step(1'b0, 1'b1, 4'b1101, pack4(1, 1, 1, 1), '0);
    idle(2);

    // Clear collides with writeback on channel 3
    step(1'b0, 1'b1, 4'b1000, pack4(0, 0, 0, 1234), '0);
    step(1'b0, 1'b1, '0, '0, 4'b1000);
    idle(2);

    // Arbitration disabled
    repeat (3) step(1'b0, 1'b0, 4'b1111, pack4(3, 3, 3, 3), '0);
    idle(1);

    // Reset while a request is in flight
    step(1'b0, 1'b1, 4'b0100, pack4(0, 0, 9, 0), '0);
    step(1'b1, 1'b1, '0, '0, '0);
    step(1'b0, 1'b1, 4'b1111, pack4(1, 1, 1, 1), '0);
    idle(2);

    // Randomised traffic
    repeat (400) begin
      logic r;
      logic e;
      logic [N-1:0] v;
      logic [N-1:0] c;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) != 0);
      v = N'($urandom);
      c = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      step(r, e, v, pack4(rand_delta(), rand_delta(), rand_delta(), rand_delta()), c);
    end
    idle(3);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_accum_arb.md
# sat_accum_arb

Round-robin scheduler that time-shares one saturating add/limit datapath between N_CH requesters. Each requester owns a signed accumulator. An accepted delta is added to that accumulator and clamped to the RES_WIDTH two's-complement range. The clamped value is written back and published on a single result port. It sits between per-axis increment sources (interpolator, feed override) and the step-rate/position consumers.

## Interface
- N_CH, 4, number of requesters/accumulators (2..16)
- IN_WIDTH, 16, signed delta width
- RES_WIDTH, 16, signed accumulator/result width; MAX = 2^(RES_WIDTH-1)-1, MIN = -2^(RES_WIDTH-1)
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  arbitration enable; low forces req_ready all 0
- req_valid  in  N_CH  per-channel request
- req_delta  in  N_CH*IN_WIDTH  signed deltas, channel i at bits [i*IN_WIDTH +: IN_WIDTH]
- req_ready  out  N_CH  one-hot-or-zero grant; handshake = valid & ready
- clr  in  N_CH  per-channel accumulator/flag clear
- res_valid  out  1  one-cycle result strobe
- res_ch  out  $clog2(N_CH)  channel of result
- res_value  out  RES_WIDTH  clamped accumulator value after update
- res_sat  out  1  this update clamped
- sat_flags  out  N_CH  sticky per-channel saturation flags
- acc  out  N_CH*RES_WIDTH  current accumulator values, same packing as req_delta

## Operation
- Arbiter: pointer ptr (reset 0). Each cycle with en=1, grant the lowest index ≥ ptr with req_valid=1, wrapping to 0. If none, no grant. After a handshake on channel g, ptr ← (g+1) mod N_CH. ptr holds when there is no handshake.
- req_ready is combinational from ptr, req_valid, en. At most one bit is set. It never asserts for a channel whose req_valid is 0.
- Stage S1 register (valid, ch, delta) loads on handshake.
- Datapath in S1 cycle: sum = sext(acc[ch]) + sext(delta), width W = max(IN_WIDTH, RES_WIDTH)+1, never overflows. Clamp: sum > MAX → MAX; sum < MIN → MIN; else truncate. sat = clamp taken.
- End of S1 cycle: acc[ch] ← clamped value, sat_flags[ch] |= sat, result registers load with res_valid=1.
- Hazards: S1 writes before the next S1 reads, so back-to-back grants to the same channel are legal. No forwarding, no stall; throughput is 1 update/cycle.
- clr[i]=1: acc[i] ← 0, sat_flags[i] ← 0 at the clock edge. This overrides a same-cycle S1 writeback to channel i. The result strobe is still emitted with the computed value. clr does not affect arbitration or handshakes.
- en=0: no new handshakes. A transaction already in S1 completes normally.
- reset: acc all 0, sat_flags 0, ptr 0, S1 valid 0, res_valid 0, res_ch 0, res_value 0, res_sat 0. A request mid-flight at reset is dropped and no result is emitted.

## Timing
- Cycle t: handshake on channel c.
- Cycle t+1: S1 computes.
- Cycle t+2: res_valid=1 with res_ch=c, and acc/sat_flags show the new value. Latency is 2 clocks from handshake edge to visible result.
- res_valid is high exactly one cycle per accepted request and is never high without a prior handshake.
- Continuous requests from all channels produce grants 0,1,…,N_CH-1,0,… with no idle cycles.

## Structure
- Package sat_accum_pkg: function sat_add(acc, delta) returning {sat, value}, and localparams MAX/MIN derived from RES_WIDTH.
- Sub-module rr_arbiter (params N; ports clock, reset, en, req, gnt one-hot, gnt_idx). It is natural to reuse for other shared units.
- Clamp may instantiate limit_comb with DATA_WIDTH=W, RES_WIDTH=RES_WIDTH. sat is derived separately by comparing the clamp output with the truncated sum.

## Test plan
- Single channel 0: acc=0, deltas +5, −7, +100 → res_value 5, −2, 98 at t+2 each; res_sat=0.
- Positive clamp: acc[1]=32760, delta +100 (RES_WIDTH=16) → res_value 32767, res_sat=1, sat_flags[1]=1. Next delta −7 → 32760, and sat_flags[1] stays 1.
- Negative clamp: acc[2]=−32768, delta −1 → −32768, res_sat=1. Delta IN_WIDTH=16 −32768 onto −1 → −32768, sat.
- Fairness: all four req_valid held high, deltas +1 → grant order 0,1,2,3,0,1. After 8 cycles each acc=2 with no gaps in res_valid. Drop req_valid[1] → order 0,2,3,0.
- Collision: handshake ch3 at t, clr[3]=1 at t+1 → res_value shows the sum at t+2, but acc[3]=0 and sat_flags[3]=0.
- Reset mid-op: handshake at t, reset at t+1 → no res_valid, all acc=0, ptr=0. The first grant after release goes to channel 0.
